// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with valid/ready handshakes, Z/N/C/V flags and a saturating op counter.
// Optional sticky overflow/carry flags are compiled in when ALU_STICKY_FLAGS_EN is defined.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_sel,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_d,
  output logic             out_z,
  output logic             out_n,
  output logic             out_c,
  output logic             out_v,
  output logic [CNT_W-1:0] op_count
`ifdef ALU_STICKY_FLAGS_EN
  ,
  input  logic             sticky_clr,
  output logic             sticky_v,
  output logic             sticky_c
`endif
);

  typedef enum logic [2:0] {
    OP_XOR  = 3'b000,
    OP_XNOR = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_OR   = 3'b100,
    OP_NOR  = 3'b101,
    OP_AND  = 3'b110,
    OP_ZERO = 3'b111
  } op_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s1Valid_q, s1Valid_d;
  logic [WIDTH-1:0] s1A_q, s1A_d;
  logic [WIDTH-1:0] s1B_q, s1B_d;
  op_e              s1Sel_q, s1Sel_d;
  logic             s1Cin_q, s1Cin_d;

  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] outD_q, outD_d;
  logic             outZ_q, outZ_d;
  logic             outN_q, outN_d;
  logic             outC_q, outC_d;
  logic             outV_q, outV_d;

  logic [CNT_W-1:0] opCount_q, opCount_d;

  logic             outAdv;
  logic             inFire;
  logic             outFire;

  logic [WIDTH-1:0] bOp;
  logic [WIDTH:0]   sumFull;
  logic             isArith;
  logic             carryIntoMsb;
  logic [WIDTH-1:0] res;
  logic             resC;
  logic             resV;

  // The output register frees up whenever it is empty or being drained; stage 1 follows it.
  assign outAdv   = !outValid_q || out_ready;
  assign in_ready = !s1Valid_q || outAdv;
  assign inFire   = in_valid && in_ready;
  assign outFire  = outValid_q && out_ready;

  always_comb begin
    s1Valid_d = s1Valid_q;
    s1A_d     = s1A_q;
    s1B_d     = s1B_q;
    s1Sel_d   = s1Sel_q;
    s1Cin_d   = s1Cin_q;
    if (inFire) begin
      s1Valid_d = 1'b1;
      s1A_d     = in_a;
      s1B_d     = in_b;
      s1Sel_d   = op_e'(in_sel);
      s1Cin_d   = in_cin;
    end else if (outAdv) begin
      s1Valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1A_q     <= '0;
      s1B_q     <= '0;
      s1Sel_q   <= OP_XOR;
      s1Cin_q   <= 1'b0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1A_q     <= s1A_d;
      s1B_q     <= s1B_d;
      s1Sel_q   <= s1Sel_d;
      s1Cin_q   <= s1Cin_d;
    end
  end

  // SUB is A + ~B + cin, so one adder serves both; carry into the MSB falls out of the sum bit.
  always_comb begin
    bOp          = (s1Sel_q == OP_SUB) ? ~s1B_q : s1B_q;
    sumFull      = {1'b0, s1A_q} + {1'b0, bOp} + {{WIDTH{1'b0}}, s1Cin_q};
    isArith      = (s1Sel_q == OP_ADD) || (s1Sel_q == OP_SUB);
    carryIntoMsb = s1A_q[WIDTH-1] ^ bOp[WIDTH-1] ^ sumFull[WIDTH-1];
    case (s1Sel_q)
      OP_XOR:  res = s1A_q ^ s1B_q;
      OP_XNOR: res = ~(s1A_q ^ s1B_q);
      OP_ADD:  res = sumFull[WIDTH-1:0];
      OP_SUB:  res = sumFull[WIDTH-1:0];
      OP_OR:   res = s1A_q | s1B_q;
      OP_NOR:  res = ~(s1A_q | s1B_q);
      OP_AND:  res = s1A_q & s1B_q;
      default: res = '0;
    endcase
    resC = isArith && sumFull[WIDTH];
    resV = isArith && (sumFull[WIDTH] ^ carryIntoMsb);
  end

  always_comb begin
    outValid_d = outValid_q;
    outD_d     = outD_q;
    outZ_d     = outZ_q;
    outN_d     = outN_q;
    outC_d     = outC_q;
    outV_d     = outV_q;
    if (outAdv) begin
      outValid_d = s1Valid_q;
      if (s1Valid_q) begin
        outD_d = res;
        outZ_d = (res == '0);
        outN_d = res[WIDTH-1];
        outC_d = resC;
        outV_d = resV;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outD_q     <= '0;
      outZ_q     <= 1'b0;
      outN_q     <= 1'b0;
      outC_q     <= 1'b0;
      outV_q     <= 1'b0;
    end else begin
      outValid_q <= outValid_d;
      outD_q     <= outD_d;
      outZ_q     <= outZ_d;
      outN_q     <= outN_d;
      outC_q     <= outC_d;
      outV_q     <= outV_d;
    end
  end

  // Counts delivered results only, parking at all-ones instead of wrapping.
  always_comb begin
    opCount_d = opCount_q;
    if (outFire && (opCount_q != '1)) begin
      opCount_d = opCount_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opCount_q <= '0;
    end else begin
      opCount_q <= opCount_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_d     = outD_q;
  assign out_z     = outZ_q;
  assign out_n     = outN_q;
  assign out_c     = outC_q;
  assign out_v     = outV_q;
  assign op_count  = opCount_q;

`ifdef ALU_STICKY_FLAGS_EN
  logic stickyV_q, stickyV_d;
  logic stickyC_q, stickyC_d;

  // A clear and a set landing together leave the flag set.
  always_comb begin
    stickyV_d = (sticky_clr ? 1'b0 : stickyV_q) | (outFire & outV_q);
    stickyC_d = (sticky_clr ? 1'b0 : stickyC_q) | (outFire & outC_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stickyV_q <= 1'b0;
      stickyC_q <= 1'b0;
    end else begin
      stickyV_q <= stickyV_d;
      stickyC_q <= stickyC_d;
    end
  end

  assign sticky_v = stickyV_q;
  assign sticky_c = stickyC_q;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: arithmetic reference model with an in-order expected queue,
// plus hand-computed literal vectors, backpressure, reset-in-flight and counter saturation.
module tb_alu_pipe;

  localparam int W  = 32;
  localparam int CW = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [2:0]    in_sel = '0;
  logic          in_cin = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_d;
  logic          out_z, out_n, out_c, out_v;
  logic [CW-1:0] op_count;
`ifdef ALU_STICKY_FLAGS_EN
  logic          sticky_clr = 1'b0;
  logic          sticky_v, sticky_c;
`endif

  int   total = 0;
  int   bad = 0;
  bit   monOn = 1'b0;
  res_t expQ[$];
  int   cntModel = 0;

  alu_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d(out_d), .out_z(out_z), .out_n(out_n), .out_c(out_c), .out_v(out_v),
    .op_count(op_count)
`ifdef ALU_STICKY_FLAGS_EN
    , .sticky_clr(sticky_clr), .sticky_v(sticky_v), .sticky_c(sticky_c)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: true integer result, overflow when it does not fit back into W signed bits.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] sel, input logic cin);
    res_t        r;
    logic [63:0] u;
    longint      sr;
    r = '0;
    case (sel)
      3'd0: r.d = a ^ b;
      3'd1: r.d = ~(a ^ b);
      3'd2: begin
        u   = {32'b0, a} + {32'b0, b} + {63'b0, cin};
        sr  = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        r.d = u[W-1:0];
        r.c = u[W];
        r.v = (sr != longint'($signed(r.d)));
      end
      3'd3: begin
        u   = {32'b0, a} + {32'b0, ~b} + {63'b0, cin};
        sr  = longint'($signed(a)) - longint'($signed(b)) - 64'sd1 + longint'(cin);
        r.d = u[W-1:0];
        r.c = u[W];
        r.v = (sr != longint'($signed(r.d)));
      end
      3'd4: r.d = a | b;
      3'd5: r.d = ~(a | b);
      3'd6: r.d = a & b;
      default: r.d = '0;
    endcase
    r.z = (r.d == '0);
    r.n = r.d[W-1];
    return r;
  endfunction

  // Every cycle: the oldest outstanding bundle must sit on the output while out_valid is high.
  always @(negedge clk) begin
    res_t h;
    if (rst) begin
      expQ.delete();
      cntModel = 0;
    end else if (monOn) begin
      chk("op_count model", {60'b0, op_count}, 64'(cntModel));
      chk("in_ready model", {63'b0, in_ready}, {63'b0, (expQ.size() < 2) || out_ready});
      if (out_valid) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL stale out_valid: got 1 want 0 (nothing outstanding)");
        end else begin
          h = expQ[0];
          chk("model out_d", {32'b0, out_d}, {32'b0, h.d});
          chk("model flags", {60'b0, out_z, out_n, out_c, out_v}, {60'b0, h.z, h.n, h.c, h.v});
          if (out_ready) begin
            void'(expQ.pop_front());
            if (cntModel < (1 << CW) - 1) cntModel++;
          end
        end
      end
      if (in_valid && in_ready) expQ.push_back(model(in_a, in_b, in_sel, in_cin));
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] sel, input logic cin);
    bit acc;
    in_a     = a;
    in_b     = b;
    in_sel   = sel;
    in_cin   = cin;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("[TB] FAIL accept timeout: in_ready stayed 0 for 200 cycles");
    end
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] ed,
                             input logic ez, input logic en, input logic ec, input logic ev);
    @(negedge clk);
    chk({name, " early"}, {63'b0, out_valid}, 64'd0);
    @(negedge clk);
    chk({name, " valid"}, {63'b0, out_valid}, 64'd1);
    chk({name, " d"}, {32'b0, out_d}, {32'b0, ed});
    chk({name, " flags"}, {60'b0, out_z, out_n, out_c, out_v}, {60'b0, ez, en, ec, ev});
    @(posedge clk);
    #1;
  endtask

  task automatic runOne(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] sel, input logic cin, input logic [W-1:0] ed,
                        input logic ez, input logic en, input logic ec, input logic ev);
    applyStimulus(a, b, sel, cin);
    checkOutput(name, ed, ez, en, ec, ev);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && expQ.size() != 0; i++) @(posedge clk);
    #1;
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain timeout: got %0d outstanding want 0", expQ.size());
    end
  endtask

  initial begin
    #1;
    chk("reset out_valid", {63'b0, out_valid}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    monOn = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", {63'b0, in_ready}, 64'd1);
    chk("post-reset out_d", {32'b0, out_d}, 64'd0);
    chk("post-reset flags", {60'b0, out_z, out_n, out_c, out_v}, 64'd0);
    chk("post-reset op_count", {60'b0, op_count}, 64'd0);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    runOne("add ovf",  32'h7FFFFFFF, 32'h00000001, 3'd2, 1'b0, 32'h80000000, 0, 1, 0, 1);
    runOne("sub eq",   32'h00000005, 32'h00000005, 3'd3, 1'b1, 32'h00000000, 1, 0, 1, 0);
    runOne("sub neg",  32'h00000000, 32'h00000001, 3'd3, 1'b1, 32'hFFFFFFFF, 0, 1, 0, 0);
    runOne("zero op",  32'hFFFFFFFF, 32'hFFFFFFFF, 3'd7, 1'b1, 32'h00000000, 1, 0, 0, 0);
    runOne("nor",      32'h00000000, 32'h00000000, 3'd5, 1'b0, 32'hFFFFFFFF, 0, 1, 0, 0);
    runOne("xor",      32'hF0F0F0F0, 32'hFF00FF00, 3'd0, 1'b1, 32'h0FF00FF0, 0, 0, 0, 0);
    runOne("xnor",     32'hF0F0F0F0, 32'hFF00FF00, 3'd1, 1'b0, 32'hF00FF00F, 0, 1, 0, 0);
    runOne("or",       32'h12340000, 32'h00005678, 3'd4, 1'b0, 32'h12345678, 0, 0, 0, 0);
    runOne("and",      32'hF0F0F0F0, 32'h3C3C3C3C, 3'd6, 1'b1, 32'h30303030, 0, 0, 0, 0);
    runOne("add wrap", 32'hFFFFFFFF, 32'h00000001, 3'd2, 1'b0, 32'h00000000, 1, 0, 1, 0);
    runOne("add cin",  32'h00000001, 32'h00000001, 3'd2, 1'b1, 32'h00000003, 0, 0, 0, 0);
    runOne("sub ovf",  32'h80000000, 32'h00000001, 3'd3, 1'b1, 32'h7FFFFFFF, 0, 0, 1, 1);

    // Three ADDs against a blocked consumer: only two fit.
    doReset();
    out_ready = 1'b0;
    applyStimulus(32'd1, 32'd2, 3'd2, 1'b0);
    applyStimulus(32'd3, 32'd4, 3'd2, 1'b0);
    in_a = 32'd5; in_b = 32'd6; in_sel = 3'd2; in_cin = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full in_ready", {63'b0, in_ready}, 64'd0);
      chk("stall out_d", {32'b0, out_d}, 64'd3);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(32'd5, 32'd6, 3'd2, 1'b0);
    drain();
    @(negedge clk);
    chk("three results op_count", {60'b0, op_count}, 64'd3);
    @(posedge clk);
    #1;

    // Reset with two bundles outstanding.
    out_ready = 1'b0;
    applyStimulus(32'hA, 32'h1, 3'd2, 1'b0);
    applyStimulus(32'hB, 32'h2, 3'd3, 1'b1);
    rst = 1'b1;
    #1;
    chk("async rst out_valid", {63'b0, out_valid}, 64'd0);
    chk("async rst op_count", {60'b0, op_count}, 64'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("after rst no stale", {63'b0, out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;

    // Mixed ops under an irregular consumer.
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          applyStimulus(32'(32'h9E3779B9 * (i + 1)), 32'(32'h7F4A7C15 ^ (i * 32'h01010101)),
                        3'(i % 8), 1'(i % 2));
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          out_ready = ((i % 3) != 0) && ((i % 7) != 5);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Counter saturation at 2^CW-1.
    doReset();
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) applyStimulus(32'(i), 32'(i), 3'd0, 1'b0);
    drain();
    @(negedge clk);
    chk("op_count saturated", {60'b0, op_count}, 64'd15);
    @(posedge clk);
    #1;

`ifdef ALU_STICKY_FLAGS_EN
    doReset();
    out_ready = 1'b1;
    runOne("sticky add", 32'h7FFFFFFF, 32'h00000001, 3'd2, 1'b0, 32'h80000000, 0, 1, 0, 1);
    runOne("sticky xor", 32'h00000003, 32'h00000001, 3'd0, 1'b0, 32'h00000002, 0, 0, 0, 0);
    @(negedge clk);
    chk("sticky_v held", {63'b0, sticky_v}, 64'd1);
    @(posedge clk);
    #1;
    sticky_clr = 1'b1;
    @(posedge clk);
    #1;
    sticky_clr = 1'b0;
    @(negedge clk);
    chk("sticky_v cleared", {63'b0, sticky_v}, 64'd0);
    @(posedge clk);
    #1;
`endif

    monOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
